addsub_hs_chunked: RTL and testbench



---
 rtl/addsub_hs_chunked.sv | 146 ++++++++++++++
 tb/tb_addsub_hs_chunked.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/addsub_hs_chunked.sv
// Chunked ripple-carry add/subtract with a 4-phase REQ/ACK handshake.
// Subtraction yields sign-magnitude |A-B| plus a NEG flag.
module addsub_hs_chunked #(
    parameter int WIDTH = 24,
    parameter int CHUNK = 8
) (
    input  logic             CLK,
    input  logic             RSTN,
    input  logic             REQ,
    input  logic             OP,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] Z,
    output logic             COUT,
    output logic             NEG,
    output logic             ZERO,
    output logic             ACK,
    output logic             BUSY
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int IW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(NCHUNK - 1);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_COMPUTE = 3'd1;
    localparam logic [2:0] S_NEGATE  = 3'd2;
    localparam logic [2:0] S_DONE    = 3'd3;
    localparam logic [2:0] S_END     = 3'd4;

    if ((WIDTH % CHUNK) != 0) begin : g_badChunk
        $error("addsub_hs_chunked: WIDTH must be a multiple of CHUNK");
    end

    logic [2:0]       r_state;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic             r_op;
    logic             r_carry;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_partial;
    logic [WIDTH-1:0] r_z;
    logic             r_cout;
    logic             r_neg;
    logic             r_zero;
    logic             r_ack;

    logic [IW-1:0]    w_base;
    logic [CHUNK-1:0] w_aChunk;
    logic [CHUNK-1:0] w_bChunk;
    logic [CHUNK:0]   w_sum;
    logic [WIDTH-1:0] w_partialNext;
    logic             w_last;

    // One chunk of the ripple adder; the partial result with this chunk merged
    // is needed so the final cycle can load Z without an extra register stage.
    always_comb begin
        w_base        = IW'(int'(r_cnt) * CHUNK);
        w_aChunk      = r_a[w_base +: CHUNK];
        w_bChunk      = r_b[w_base +: CHUNK];
        w_sum         = {1'b0, w_aChunk} + {1'b0, w_bChunk} + {{CHUNK{1'b0}}, r_carry};
        w_partialNext = r_partial;
        w_partialNext[w_base +: CHUNK] = w_sum[CHUNK-1:0];
        w_last        = (r_cnt == LAST_CNT);
    end

    always_ff @(posedge CLK) begin
        if (!RSTN) begin
            r_state   <= S_IDLE;
            r_a       <= '0;
            r_b       <= '0;
            r_op      <= 1'b0;
            r_carry   <= 1'b0;
            r_cnt     <= '0;
            r_partial <= '0;
            r_z       <= '0;
            r_cout    <= 1'b0;
            r_neg     <= 1'b0;
            r_zero    <= 1'b0;
            r_ack     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (REQ) begin
                        // Subtract as A + ~B + 1, the +1 entering as the initial carry.
                        r_a       <= A;
                        r_b       <= OP ? ~B : B;
                        r_op      <= OP;
                        r_carry   <= OP;
                        r_cnt     <= '0;
                        r_partial <= '0;
                        r_state   <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    r_partial <= w_partialNext;
                    r_carry   <= w_sum[CHUNK];
                    if (w_last) begin
                        r_cnt <= '0;
                        if (r_op && !w_sum[CHUNK]) begin
                            r_state <= S_NEGATE;
                        end else begin
                            r_z     <= w_partialNext;
                            r_cout  <= ~r_op & w_sum[CHUNK];
                            r_neg   <= 1'b0;
                            r_zero  <= (w_partialNext == '0);
                            r_ack   <= 1'b1;
                            r_state <= S_DONE;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_NEGATE: begin
                    r_z     <= ~r_partial + WIDTH'(1);
                    r_cout  <= 1'b0;
                    r_neg   <= 1'b1;
                    r_zero  <= 1'b0;
                    r_ack   <= 1'b1;
                    r_state <= S_DONE;
                end
                S_DONE: begin
                    if (!REQ) begin
                        r_ack   <= 1'b0;
                        r_state <= S_END;
                    end
                end
                S_END: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign Z    = r_z;
    assign COUT = r_cout;
    assign NEG  = r_neg;
    assign ZERO = r_zero;
    assign ACK  = r_ack;
    assign BUSY = (r_state != S_IDLE);

endmodule

// File: tb/tb_addsub_hs_chunked.sv
// Bench for addsub_hs_chunked: three instances (CHUNK 8, 4, 24) share one stimulus
// stream and are checked every cycle against a transaction-level model.
module tb_addsub_hs_chunked;

    logic        CLK  = 1'b0;
    logic        RSTN = 1'b0;
    logic        REQ  = 1'b0;
    logic        OP   = 1'b0;
    logic [23:0] A    = '0;
    logic [23:0] B    = '0;

    logic [23:0] zV    [3];
    logic        coutV [3];
    logic        negV  [3];
    logic        zeroV [3];
    logic        ackV  [3];
    logic        busyV [3];

    int total = 0;
    int bad   = 0;
    bit checkEn = 1'b0;

    always #5 CLK = ~CLK;

    addsub_hs_chunked #(.WIDTH(24), .CHUNK(8)) u0 (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .OP(OP), .A(A), .B(B),
        .Z(zV[0]), .COUT(coutV[0]), .NEG(negV[0]), .ZERO(zeroV[0]), .ACK(ackV[0]), .BUSY(busyV[0])
    );
    addsub_hs_chunked #(.WIDTH(24), .CHUNK(4)) u1 (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .OP(OP), .A(A), .B(B),
        .Z(zV[1]), .COUT(coutV[1]), .NEG(negV[1]), .ZERO(zeroV[1]), .ACK(ackV[1]), .BUSY(busyV[1])
    );
    addsub_hs_chunked #(.WIDTH(24), .CHUNK(24)) u2 (
        .CLK(CLK), .RSTN(RSTN), .REQ(REQ), .OP(OP), .A(A), .B(B),
        .Z(zV[2]), .COUT(coutV[2]), .NEG(negV[2]), .ZERO(zeroV[2]), .ACK(ackV[2]), .BUSY(busyV[2])
    );

    // Model: phase 0 idle, 1 working, 2 acknowledged, 3 cool-down.
    int          nch    [3] = '{3, 6, 1};
    int          mPhase [3];
    int          mLeft  [3];
    logic [23:0] mZ     [3];
    logic        mCout  [3];
    logic        mNeg   [3];
    logic        mZero  [3];
    logic        mAck   [3];
    logic [23:0] pZ     [3];
    logic        pCout  [3];
    logic        pNeg   [3];

    function automatic void golden(input logic op, input logic [23:0] a, input logic [23:0] b,
                                   output logic [23:0] z, output logic c, output logic n);
        logic [24:0] s;
        if (!op) begin
            s = {1'b0, a} + {1'b0, b};
            z = s[23:0];
            c = s[24];
            n = 1'b0;
        end else if (a >= b) begin
            z = a - b;
            c = 1'b0;
            n = 1'b0;
        end else begin
            z = b - a;
            c = 1'b0;
            n = 1'b1;
        end
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Advance the model on each edge from the same inputs the DUTs sample.
    always @(posedge CLK) begin
        for (int k = 0; k < 3; k++) begin
            if (!RSTN) begin
                mPhase[k] = 0;
                mLeft[k]  = 0;
                mZ[k]     = '0;
                mCout[k]  = 1'b0;
                mNeg[k]   = 1'b0;
                mZero[k]  = 1'b0;
                mAck[k]   = 1'b0;
            end else begin
                case (mPhase[k])
                    0: if (REQ) begin
                        golden(OP, A, B, pZ[k], pCout[k], pNeg[k]);
                        mLeft[k]  = nch[k] + (pNeg[k] ? 1 : 0);
                        mPhase[k] = 1;
                    end
                    1: begin
                        mLeft[k]--;
                        if (mLeft[k] == 0) begin
                            mZ[k]     = pZ[k];
                            mCout[k]  = pCout[k];
                            mNeg[k]   = pNeg[k];
                            mZero[k]  = (pZ[k] == 24'h0);
                            mAck[k]   = 1'b1;
                            mPhase[k] = 2;
                        end
                    end
                    2: if (!REQ) begin
                        mAck[k]   = 1'b0;
                        mPhase[k] = 3;
                    end
                    default: mPhase[k] = 0;
                endcase
            end
        end
    end

    always @(negedge CLK) begin
        if (checkEn) begin
            for (int k = 0; k < 3; k++) begin
                checkOutput($sformatf("u%0d Z", k),    32'(zV[k]),    32'(mZ[k]));
                checkOutput($sformatf("u%0d COUT", k), 32'(coutV[k]), 32'(mCout[k]));
                checkOutput($sformatf("u%0d NEG", k),  32'(negV[k]),  32'(mNeg[k]));
                checkOutput($sformatf("u%0d ZERO", k), 32'(zeroV[k]), 32'(mZero[k]));
                checkOutput($sformatf("u%0d ACK", k),  32'(ackV[k]),  32'(mAck[k]));
                checkOutput($sformatf("u%0d BUSY", k), 32'(busyV[k]), 32'(mPhase[k] != 0));
            end
        end
    end

    task automatic applyStimulus(input logic op, input logic [23:0] a, input logic [23:0] b);
        @(negedge CLK);
        OP  = op;
        A   = a;
        B   = b;
        REQ = 1'b1;
    endtask

    // Latency in edges after the first edge following the drive; 99 marks a timeout.
    task automatic waitAck(output int l0, output int l1, output int l2);
        int l [3];
        l = '{99, 99, 99};
        @(posedge CLK);
        for (int c = 1; c <= 20; c++) begin
            @(posedge CLK);
            #1;
            for (int k = 0; k < 3; k++)
                if (l[k] == 99 && ackV[k]) l[k] = c;
            if (l[0] != 99 && l[1] != 99 && l[2] != 99) break;
        end
        l0 = l[0];
        l1 = l[1];
        l2 = l[2];
    endtask

    task automatic releaseReq();
        @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
    endtask

    int lat0, lat1, lat2, ackCnt;

    initial begin
        @(posedge CLK);
        #1 checkEn = 1'b1;
        @(negedge CLK);
        checkOutput("reset Z", 32'(zV[0]), 32'h0);
        checkOutput("reset ACK", 32'(ackV[0]), 32'h0);
        checkOutput("reset BUSY", 32'(busyV[0]), 32'h0);
        RSTN = 1'b1;

        // Add with carry out of the top chunk, REQ held long past ACK.
        applyStimulus(1'b0, 24'hFFFFFF, 24'h000001);
        waitAck(lat0, lat1, lat2);
        checkOutput("add lat c8", 32'(lat0), 32'd3);
        checkOutput("add lat c4", 32'(lat1), 32'd6);
        checkOutput("add lat c24", 32'(lat2), 32'd1);
        checkOutput("add Z", 32'(zV[0]), 32'h0);
        checkOutput("add COUT", 32'(coutV[0]), 32'h1);
        checkOutput("add ZERO", 32'(zeroV[0]), 32'h1);
        checkOutput("add NEG", 32'(negV[0]), 32'h0);
        repeat (10) @(negedge CLK);
        checkOutput("hold ACK", 32'(ackV[0]), 32'h1);
        releaseReq();
        checkOutput("drop ACK", 32'(ackV[0]), 32'h0);
        checkOutput("end BUSY", 32'(busyV[0]), 32'h1);

        // Negative subtract.
        applyStimulus(1'b1, 24'h000010, 24'h000020);
        waitAck(lat0, lat1, lat2);
        checkOutput("neg lat c8", 32'(lat0), 32'd4);
        checkOutput("neg lat c4", 32'(lat1), 32'd7);
        checkOutput("neg lat c24", 32'(lat2), 32'd2);
        checkOutput("neg Z", 32'(zV[0]), 32'h10);
        checkOutput("neg NEG", 32'(negV[0]), 32'h1);
        checkOutput("neg COUT", 32'(coutV[0]), 32'h0);
        checkOutput("neg ZERO", 32'(zeroV[0]), 32'h0);
        releaseReq();

        // Equal operands, then a borrow rippling through two chunks.
        applyStimulus(1'b1, 24'h123456, 24'h123456);
        waitAck(lat0, lat1, lat2);
        checkOutput("eq lat", 32'(lat0), 32'd3);
        checkOutput("eq Z", 32'(zV[0]), 32'h0);
        checkOutput("eq ZERO", 32'(zeroV[0]), 32'h1);
        checkOutput("eq NEG", 32'(negV[0]), 32'h0);
        releaseReq();
        applyStimulus(1'b1, 24'h010000, 24'h000001);
        waitAck(lat0, lat1, lat2);
        checkOutput("borrow lat", 32'(lat0), 32'd3);
        checkOutput("borrow Z", 32'(zV[0]), 32'h00FFFF);
        checkOutput("borrow NEG", 32'(negV[0]), 32'h0);
        releaseReq();

        // Operands changed after acceptance must not matter.
        applyStimulus(1'b0, 24'h000100, 24'h000023);
        fork
            begin
                @(posedge CLK);
                @(negedge CLK);
                A  = 24'hFFFFFF;
                B  = 24'h000FFF;
                OP = 1'b1;
            end
        join_none
        waitAck(lat0, lat1, lat2);
        checkOutput("latched Z", 32'(zV[0]), 32'h000123);
        checkOutput("latched COUT", 32'(coutV[0]), 32'h0);

        // REQ reasserted while in END is only taken one cycle later.
        @(negedge CLK);
        REQ = 1'b0;
        @(negedge CLK);
        checkOutput("end ACK", 32'(ackV[0]), 32'h0);
        OP  = 1'b0;
        A   = 24'h000001;
        B   = 24'h000002;
        REQ = 1'b1;
        waitAck(lat0, lat1, lat2);
        checkOutput("reassert lat c8", 32'(lat0), 32'd4);
        checkOutput("reassert lat c24", 32'(lat2), 32'd2);
        checkOutput("reassert Z", 32'(zV[0]), 32'h000003);
        releaseReq();

        // REQ dropped mid-compute: ACK pulses for exactly one cycle.
        applyStimulus(1'b0, 24'h000F0F, 24'h0000F1);
        @(posedge CLK);
        @(negedge CLK);
        REQ = 1'b0;
        ackCnt = 0;
        repeat (12) begin
            @(negedge CLK);
            if (ackV[0]) ackCnt++;
        end
        checkOutput("pulse ACK count", 32'(ackCnt), 32'd1);
        checkOutput("pulse Z", 32'(zV[0]), 32'h001000);
        checkOutput("persist Z c4", 32'(zV[1]), 32'h001000);

        // Reset during the second compute cycle aborts the operation.
        applyStimulus(1'b0, 24'h123456, 24'h111111);
        @(posedge CLK);
        @(negedge CLK);
        @(posedge CLK);
        @(negedge CLK);
        RSTN = 1'b0;
        REQ  = 1'b0;
        @(negedge CLK);
        checkOutput("abort Z", 32'(zV[0]), 32'h0);
        checkOutput("abort ACK", 32'(ackV[0]), 32'h0);
        checkOutput("abort BUSY", 32'(busyV[0]), 32'h0);
        checkOutput("abort Z c24", 32'(zV[2]), 32'h0);
        RSTN = 1'b1;
        applyStimulus(1'b0, 24'h00FFFF, 24'h000001);
        waitAck(lat0, lat1, lat2);
        checkOutput("post lat c8", 32'(lat0), 32'd3);
        checkOutput("post lat c4", 32'(lat1), 32'd6);
        checkOutput("post lat c24", 32'(lat2), 32'd1);
        checkOutput("post Z c8", 32'(zV[0]), 32'h010000);
        checkOutput("post Z c4", 32'(zV[1]), 32'h010000);
        checkOutput("post Z c24", 32'(zV[2]), 32'h010000);
        releaseReq();

        // Small negative subtract across all chunk sizes.
        applyStimulus(1'b1, 24'h000005, 24'h000007);
        waitAck(lat0, lat1, lat2);
        checkOutput("sweep lat c4", 32'(lat1), 32'd7);
        checkOutput("sweep lat c24", 32'(lat2), 32'd2);
        checkOutput("sweep Z c4", 32'(zV[1]), 32'h2);
        checkOutput("sweep Z c24", 32'(zV[2]), 32'h2);
        checkOutput("sweep NEG c4", 32'(negV[1]), 32'h1);
        checkOutput("sweep NEG c24", 32'(negV[2]), 32'h1);
        releaseReq();

        repeat (3) @(negedge CLK);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
